// File: rtl/wb_pkg.sv
// Shared wishbone bus widths and arbiter state encoding.
package wb_pkg;
   localparam int WB_ADDR_W = 30;
   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } arb_state_t;
endpackage

// File: rtl/wb_if.sv
// Pipelined 32-bit wishbone bus bundle.
interface wb_if;
   import wb_pkg::*;

   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [WB_SEL_W-1:0]  sel;
   logic [WB_ADDR_W-1:0] addr;
   logic [WB_DATA_W-1:0] mosi_data;
   logic [WB_DATA_W-1:0] miso_data;
   logic                 ack;
   logic                 err;
   logic                 stall;

   modport master (
      output cyc, stb, we, sel, addr, mosi_data,
      input  miso_data, ack, err, stall
   );

   modport slave (
      input  cyc, stb, we, sel, addr, mosi_data,
      output miso_data, ack, err, stall
   );
endinterface

// File: rtl/wb_watchdog.sv
// Outstanding-request counter and no-progress timer for one bus owner.
// Raises a single-cycle abort when the owner has been stuck too long.
module wb_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic active,
   input  logic clear,
   input  logic stb_req,
   input  logic stall,
   input  logic resp,
   output logic abort,
   output logic sat,
   output logic resp_ok
);
   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt;
   logic [WD_W-1:0]  wdog;
   logic pending;
   logic req_go;
   logic accept;
   logic stalled;

   assign pending = cnt != '0;
   assign req_go  = stb_req & ~stall;
   assign accept  = req_go & ~abort;
   // responses with nothing in flight belong to an abandoned cycle
   assign resp_ok = resp & (pending | req_go);
   assign stalled = active & (pending | (stb_req & stall)) & ~resp_ok;
   assign abort   = (TIMEOUT != 0) && stalled && (wdog == WD_LAST);
   assign sat     = cnt == CNT_MAX;

   always_ff @(posedge i_clk) begin
      if (i_reset || clear || abort)
         cnt <= '0;
      else if (accept && !resp_ok && !sat)
         cnt <= cnt + CNT_W'(1);
      else if (resp_ok && !accept)
         cnt <= cnt - CNT_W'(1);

      if (i_reset || clear || abort || !stalled || TIMEOUT == 0)
         wdog <= '0;
      else
         wdog <= wdog + WD_W'(1);
   end
endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-master round-robin wishbone arbiter; the grant is held for the
// owner's whole cycle and hung cycles are aborted with err.
module wb_arbiter_2to1
   import wb_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   wb_if.slave        m0,
   wb_if.slave        m1,
   wb_if.master       s,
   output logic [1:0] o_grant,
   output logic       o_timeout
);
   arb_state_t state, state_n;
   logic last, last_n;
   logic own0, own1;
   logic own_cyc, own_stb, stb_req;
   logic abort, sat, resp_ok;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_n;
         last  <= last_n;
      end
   end

   always_comb begin
      state_n = state;
      last_n  = last;
      unique case (state)
         IDLE: begin
            if (m0.cyc && m1.cyc)
               state_n = last ? G0 : G1;
            else if (m0.cyc)
               state_n = G0;
            else if (m1.cyc)
               state_n = G1;
         end
         G0: begin
            if (!m0.cyc) begin
               last_n  = 1'b0;
               state_n = m1.cyc ? G1 : IDLE;
            end
         end
         G1: begin
            if (!m1.cyc) begin
               last_n  = 1'b1;
               state_n = m0.cyc ? G0 : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign own0    = state == G0;
   assign own1    = state == G1;
   assign own_cyc = own1 ? m1.cyc : (own0 & m0.cyc);
   assign own_stb = own1 ? m1.stb : (own0 & m0.stb);
   assign stb_req = own_stb & own_cyc & ~sat;

   wb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wd (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .active  (own0 | own1),
      .clear   (state_n != state),
      .stb_req (stb_req),
      .stall   (s.stall),
      .resp    (s.ack | s.err),
      .abort   (abort),
      .sat     (sat),
      .resp_ok (resp_ok)
   );

   assign s.cyc       = own_cyc & ~abort;
   assign s.stb       = stb_req & ~abort;
   assign s.we        = own1 ? m1.we        : m0.we;
   assign s.sel       = own1 ? m1.sel       : m0.sel;
   assign s.addr      = own1 ? m1.addr      : m0.addr;
   assign s.mosi_data = own1 ? m1.mosi_data : m0.mosi_data;

   assign m0.ack       = own0 & s.ack & resp_ok;
   assign m0.err       = own0 & ((s.err & resp_ok) | abort);
   assign m0.stall     = ~own0 | s.stall | sat;
   assign m0.miso_data = s.miso_data;

   assign m1.ack       = own1 & s.ack & resp_ok;
   assign m1.err       = own1 & ((s.err & resp_ok) | abort);
   assign m1.stall     = ~own1 | s.stall | sat;
   assign m1.miso_data = s.miso_data;

   assign o_grant   = {own1, own0};
   assign o_timeout = abort;
endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1: a per-cycle vector table plus
// hand sequences for bursts, timeout, reset and counter saturation.
module tb_wb_arbiter_2to1;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_if m0 ();
   wb_if m1 ();
   wb_if s ();
   wb_if m0b ();
   wb_if m1b ();
   wb_if sb ();

   logic [1:0] grant, grant_b;
   logic       tmo, tmo_b;

   wb_arbiter_2to1 #(.TIMEOUT(8), .CNT_W(4)) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .m0        (m0),
      .m1        (m1),
      .s         (s),
      .o_grant   (grant),
      .o_timeout (tmo)
   );

   wb_arbiter_2to1 #(.TIMEOUT(0), .CNT_W(2)) dut_sat (
      .i_clk     (clk),
      .i_reset   (rst),
      .m0        (m0b),
      .m1        (m1b),
      .s         (sb),
      .o_grant   (grant_b),
      .o_timeout (tmo_b)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // cyc/stb/mack/merr/mstall are {m1,m0}; sl is {stall,ack,err};
   // sbus is {s.cyc,s.stb}
   typedef struct packed {
      logic [1:0] cyc;
      logic [1:0] stb;
      logic [2:0] sl;
      logic [1:0] grant;
      logic [1:0] sbus;
      logic [1:0] mack;
      logic [1:0] merr;
      logic [1:0] mstall;
   } vec_t;

   localparam int NV = 28;
   vec_t vt [NV];

   initial begin
      #500000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int peak, acks, tmo_seen;

      vt = '{
         {2'b11,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,2'b11},
         {2'b11,2'b01,3'b000,2'b01,2'b11,2'b00,2'b00,2'b10},
         {2'b11,2'b00,3'b010,2'b01,2'b10,2'b01,2'b00,2'b10},
         {2'b10,2'b00,3'b000,2'b01,2'b00,2'b00,2'b00,2'b10},
         {2'b10,2'b10,3'b000,2'b10,2'b11,2'b00,2'b00,2'b01},
         {2'b10,2'b00,3'b010,2'b10,2'b10,2'b10,2'b00,2'b01},
         {2'b00,2'b00,3'b000,2'b10,2'b00,2'b00,2'b00,2'b01},
         {2'b11,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,2'b11},
         {2'b01,2'b00,3'b000,2'b01,2'b10,2'b00,2'b00,2'b10},
         {2'b10,2'b00,3'b000,2'b01,2'b00,2'b00,2'b00,2'b10},
         {2'b10,2'b00,3'b000,2'b10,2'b10,2'b00,2'b00,2'b01},
         {2'b00,2'b00,3'b000,2'b10,2'b00,2'b00,2'b00,2'b01},
         {2'b01,2'b01,3'b000,2'b00,2'b00,2'b00,2'b00,2'b11},
         {2'b01,2'b01,3'b000,2'b01,2'b11,2'b00,2'b00,2'b10},
         {2'b01,2'b00,3'b100,2'b01,2'b10,2'b00,2'b00,2'b11},
         {2'b01,2'b00,3'b010,2'b01,2'b10,2'b01,2'b00,2'b10},
         {2'b00,2'b00,3'b000,2'b01,2'b00,2'b00,2'b00,2'b10},
         {2'b00,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,2'b11},
         {2'b01,2'b01,3'b000,2'b00,2'b00,2'b00,2'b00,2'b11},
         {2'b01,2'b01,3'b000,2'b01,2'b11,2'b00,2'b00,2'b10},
         {2'b10,2'b00,3'b000,2'b01,2'b00,2'b00,2'b00,2'b10},
         {2'b10,2'b00,3'b010,2'b10,2'b10,2'b00,2'b00,2'b01},
         {2'b00,2'b00,3'b000,2'b10,2'b00,2'b00,2'b00,2'b01},
         {2'b10,2'b10,3'b000,2'b00,2'b00,2'b00,2'b00,2'b11},
         {2'b10,2'b10,3'b000,2'b10,2'b11,2'b00,2'b00,2'b01},
         {2'b10,2'b00,3'b001,2'b10,2'b10,2'b00,2'b10,2'b01},
         {2'b00,2'b00,3'b000,2'b10,2'b00,2'b00,2'b00,2'b01},
         {2'b00,2'b00,3'b000,2'b00,2'b00,2'b00,2'b00,2'b11}
      };

      m0.cyc = 1'b1; m0.stb = 1'b0; m0.we = 1'b1; m0.sel = 4'hF;
      m0.addr = 30'h100; m0.mosi_data = 32'hDEADBEEF;
      m1.cyc = 1'b1; m1.stb = 1'b0; m1.we = 1'b0; m1.sel = 4'h3;
      m1.addr = 30'h200; m1.mosi_data = 32'h12345678;
      s.stall = 1'b0; s.ack = 1'b0; s.err = 1'b0;
      s.miso_data = 32'hCAFEF00D;
      m0b.cyc = 1'b0; m0b.stb = 1'b0; m0b.we = 1'b1; m0b.sel = 4'hF;
      m0b.addr = 30'h40; m0b.mosi_data = 32'h0;
      m1b.cyc = 1'b0; m1b.stb = 1'b0; m1b.we = 1'b0; m1b.sel = 4'h0;
      m1b.addr = 30'h0; m1b.mosi_data = 32'h0;
      sb.stall = 1'b0; sb.ack = 1'b0; sb.err = 1'b0;
      sb.miso_data = 32'h0;

      // reset dominates requests
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", grant, 2'b00);
      chk("rst_scyc_stb", {s.cyc, s.stb}, 2'b00);
      chk("rst_stall", {m1.stall, m0.stall}, 2'b11);
      chk("rst_ack_err", {m1.ack, m0.ack, m1.err, m0.err}, 4'h0);
      chk("rst_tmo", tmo, 1'b0);
      chk("rst_miso", m1.miso_data, 32'hCAFEF00D);
      chk("rst_grant_b", {grant_b, sb.cyc, tmo_b}, 4'b0000);
      tick();
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         m0.cyc = vt[i].cyc[0];
         m1.cyc = vt[i].cyc[1];
         m0.stb = vt[i].stb[0];
         m1.stb = vt[i].stb[1];
         {s.stall, s.ack, s.err} = vt[i].sl;
         @(negedge clk);
         chk($sformatf("vec%0d_bus", i),
             {grant, s.cyc, s.stb, m1.ack, m0.ack,
              m1.err, m0.err, m1.stall, m0.stall},
             {vt[i].grant, vt[i].sbus, vt[i].mack,
              vt[i].merr, vt[i].mstall});
         chk($sformatf("vec%0d_addr", i), s.addr,
             (vt[i].grant == 2'b10) ? 30'h200 : 30'h100);
         chk($sformatf("vec%0d_wdata", i),
             {s.we, s.sel, s.mosi_data},
             (vt[i].grant == 2'b10) ? {1'b0, 4'h3, 32'h12345678}
                                    : {1'b1, 4'hF, 32'hDEADBEEF});
         chk($sformatf("vec%0d_tmo", i), tmo, 1'b0);
         tick();
      end
      {s.stall, s.ack, s.err} = 3'b000;

      // pipelined burst from m1, each stb stalled once
      m1.cyc = 1'b1;
      tick();
      peak = 0; acks = 0; tmo_seen = 0;
      for (int i = 0; i < 4; i++) begin
         m1.stb = 1'b1;
         s.stall = 1'b1;
         @(negedge clk);
         chk($sformatf("burst%0d_stalled", i), {m1.stall, s.stb}, 2'b11);
         tmo_seen += int'(tmo);
         tick();
         if (int'(dut.u_wd.cnt) > peak) peak = int'(dut.u_wd.cnt);
         s.stall = 1'b0;
         @(negedge clk);
         chk($sformatf("burst%0d_go", i), {m1.stall, s.stb}, 2'b01);
         tmo_seen += int'(tmo);
         tick();
         if (int'(dut.u_wd.cnt) > peak) peak = int'(dut.u_wd.cnt);
      end
      m1.stb = 1'b0;
      for (int j = 0; j < 4; j++) begin
         s.ack = 1'b1;
         @(negedge clk);
         acks += int'(m1.ack);
         tmo_seen += int'(tmo);
         tick();
      end
      s.ack = 1'b0;
      @(negedge clk);
      chk("burst_peak", peak, 4);
      chk("burst_acks", acks, 4);
      chk("burst_cnt_end", dut.u_wd.cnt, 0);
      chk("burst_no_tmo", tmo_seen, 0);
      m1.cyc = 1'b0;
      tick();
      tick();

      // watchdog: m0 owns, slave never acks, m1 waits
      m0.cyc = 1'b1;
      m1.cyc = 1'b1;
      tick();
      m0.stb = 1'b1;
      @(negedge clk);
      chk("wd_grant", {grant, s.stb}, 3'b011);
      tick();
      m0.stb = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk($sformatf("wd%0d_tmo", k), tmo, k == 8);
         chk($sformatf("wd%0d_err", k), m0.err, k == 8);
         chk($sformatf("wd%0d_scyc", k), s.cyc, k != 8);
         chk($sformatf("wd%0d_m1stall", k), m1.stall, 1'b1);
         tick();
      end
      m0.cyc = 1'b0;
      @(negedge clk);
      chk("wd_hold_grant", grant, 2'b01);
      tick();
      @(negedge clk);
      chk("wd_handoff", {grant, m1.stall}, 3'b100);
      m1.cyc = 1'b0;
      tick();
      tick();

      // reset in the middle of an m1 cycle
      m1.cyc = 1'b1;
      tick();
      m1.stb = 1'b1;
      tick();
      m1.stb = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_before", {grant, m1.err}, 3'b100);
      tick();
      rst = 1'b0;
      m1.cyc = 1'b0;
      m0.cyc = 1'b1;
      s.ack = 1'b1;
      @(negedge clk);
      chk("mrst_idle", {grant, s.cyc}, 3'b000);
      chk("mrst_no_resp", {m1.ack, m1.err, m0.ack, m0.err}, 4'h0);
      tick();
      s.ack = 1'b0;
      @(negedge clk);
      chk("mrst_regrant", {grant, s.cyc}, 3'b011);
      m0.cyc = 1'b0;
      tick();
      tick();

      // saturation of a 2-bit counter with the watchdog disabled
      m0b.cyc = 1'b1;
      tick();
      m0b.stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("sat%0d_go", i), {sb.stb, m0b.stall}, 2'b10);
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("sat_hold%0d", k),
             {sb.stb, m0b.stall, tmo_b, m0b.err}, 4'b0100);
         tick();
      end
      sb.ack = 1'b1;
      @(negedge clk);
      chk("sat_ack", {m0b.ack, m0b.stall, sb.stb}, 3'b110);
      tick();
      sb.ack = 1'b0;
      @(negedge clk);
      chk("sat_release", {sb.stb, m0b.stall}, 2'b10);
      tick();
      m0b.stb = 1'b0;
      @(negedge clk);
      chk("sat_cnt", dut_sat.u_wd.cnt, 3);
      m0b.cyc = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_arbiter_2to1.md
Name: wb_arbiter_2to1

Overview:
- Two-master to one-slave arbiter for the pipelined 32-bit wishbone bus (cyc/stb/we/sel/addr[29:0]/mosi_data in one direction; miso_data/ack/err/stall in the other).
- Placed between the CPU instruction/data ports (or CPU and the ihex loader) and the shared memory/peripheral bus.
- Round-robin grant with bus lock for the whole cycle; cyc is held while the owner keeps its cycle open.
- Watchdog aborts hung cycles with err.

Parameters:
- TIMEOUT, 255: cycles without progress before abort; 0 disables the watchdog.
- CNT_W, 4: width of the outstanding-request counter.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous reset, active-high.
- m0  wishbone interface (slave side)  —  requester 0; wins ties after reset.
- m1  wishbone interface (slave side)  —  requester 1.
- s  wishbone interface (master side)  —  shared downstream bus.
- o_grant  output  2  one-hot current owner; 00 when idle.
- o_timeout  output  1  one-cycle pulse when the watchdog aborts a cycle.

Behaviour:
- Reset values:
  - state=IDLE, last=1, outstanding=0, wdog=0, o_grant=00, o_timeout=0.
  - s.cyc=s.stb=0.
  - Both masters see ack=err=0 and stall=1.
- States are IDLE, G0 and G1. The grant is registered, so the earliest slave stb is one cycle after the master's cyc rises.
- IDLE:
  - Only m0.cyc → G0.
  - Only m1.cyc → G1.
  - Both → the master not equal to last.
  - Neither → stay.
- Gx:
  - Stay while mx.cyc=1.
  - mx.cyc=0 and other.cyc=1 → G(other), direct handoff with no idle cycle.
  - mx.cyc=0 and other.cyc=0 → IDLE.
  - Set last=x on leaving Gx.
- Forwarding in Gx:
  - s.cyc = mx.cyc & ~abort.
  - s.stb = mx.stb & mx.cyc & ~abort.
  - s.we/sel/addr/mosi_data = mx fields.
  - mx sees ack=s.ack, err=s.err|abort, stall=s.stall, miso_data=s.miso_data.
- Non-owner: ack=0, err=0, stall=1; miso_data = s.miso_data (don't-care).
- In IDLE, s.cyc=s.stb=0 and s.addr/data hold m0 fields (don't-care).
- Outstanding counter:
  - +1 on s.stb & ~s.stall; −1 on s.ack|s.err; both in the same cycle → unchanged.
  - Cleared on grant change and on abort.
  - Saturates at 2^CNT_W−1. While saturated, the owner sees stall=1 and s.stb is suppressed.
- Watchdog:
  - wdog increments each cycle in Gx where (outstanding>0 or s.stb&s.stall) and no s.ack/s.err.
  - Reset to 0 otherwise, and on grant change.
  - When wdog==TIMEOUT−1 and the next cycle would still be stalled, abort=1 for exactly one cycle: owner sees err=1, s.cyc=0, o_timeout=1. wdog and outstanding then clear.
  - The owner stays granted until it drops cyc.
- Owner drops cyc with outstanding>0: the cycle is aborted per wishbone B4, the counter clears, and late slave acks are not routed to either master.
- Simultaneous handoff and request: a new m(x) cyc rising in the same cycle the other drops is evaluated as a normal request.
- i_reset mid-cycle forces IDLE immediately (s.cyc=0 the next cycle); no err is generated.

Decomposition:
- Shared package wb_pkg: typedef arb_state_t {IDLE, G0, G1}; localparams WB_ADDR_W=30, WB_DATA_W=32, WB_SEL_W=4.
- The wishbone interface definition is reused unchanged.
- Sub-module wb_watchdog (outstanding counter + timeout counter → abort pulse). It is the one natural split, reusable for a future N-way arbiter.

Test Plan:
- Single master: m0 cyc+stb write addr=0x100, data=0xDEADBEEF, s stall=0, ack after 2 cycles → s sees stb one cycle after m0.cyc; m0 ack once; o_grant=01; m1 stall=1 throughout.
- Tie: m0 and m1 raise cyc in the same cycle out of reset → G0 first. After m0 drops cyc, G1 with no idle cycle. Repeat the tie → G0 again, because last=1.
- Pipelined burst: m1 issues 4 stb with s.stall=1 for 1 cycle each → outstanding peaks correctly. 4 acks return → m1 sees 4 acks, and the counter is 0 at the end.
- Timeout with TIMEOUT=8: m0 stb accepted, slave never acks → err to m0 and o_timeout exactly 8 cycles after the last progress, s.cyc=0 for that cycle. m1 stays stalled until m0 drops cyc.
- Reset mid-cycle: i_reset asserted during a G1 burst → next cycle o_grant=00, s.cyc=0, no ack/err to m1. Afterwards m0 request is granted normally.
- Saturation with CNT_W=2: slave holds acks, m0 issues 4 stb → the 4th stb is stalled. One ack releases it.
